count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Control FSM for a 4-bit up-counter datapath (sync reset, active-high enable, registered count).
//  Drives the counter's reset/enable, divides the clock by a prescale value, and compares the
//  count against a programmed terminal value. Signals terminal events in one-shot or periodic
//  mode. Sits between the control logic (start/stop) and one counter instance.
// PARAMETERS
//  WIDTH       4  counter / terminal-count width in bits
//  PRESCALE_W  4  prescale field width; counter advances once per (prescale+1) RUN cycles
// PORTS
//  clock        in   1           system clock, all state updates on posedge
//  reset        in   1           synchronous, active-high reset
//  start        in   1           request a run; sampled on posedge
//  stop         in   1           abort the run; priority over start and tick
//  periodic     in   1           1 = auto-restart after terminal, 0 = one-shot
//  term         in   WIDTH       terminal count, latched on accepted start
//  prescale     in   PRESCALE_W  divide value P, latched on accepted start
//  cnt_value    in   WIDTH       current counter output
//  cnt_reset    out  1           drives the counter's reset input
//  cnt_enable   out  1           drives the counter's enable input
//  busy         out  1           1 in CLEAR or RUN
//  done         out  1           1 while in DONE (one-shot finished)
//  tick         out  1           one-cycle pulse when terminal is reached
//  start_err    out  1           one-cycle pulse: start seen while busy
// BEHAVIOUR
//  - State: IDLE, CLEAR, RUN, DONE. Regs: state, term_q, presc_q, per_q, div (PRESCALE_W).
//  - Outputs are combinational from regs + stop/start; no extra register stage.
//  - reset=1: next state IDLE, div=0, term_q/presc_q/per_q=0. cnt_reset=1 whenever reset=1.
//    busy/done/tick/cnt_enable/start_err=0 during and after reset. Reset mid-run aborts silently.
//  - IDLE: cnt_enable=0, cnt_reset=0. start&!stop -> latch term/prescale/periodic, go CLEAR.
//  - CLEAR (1 cycle): cnt_reset=1, div<=0; -> RUN (stop -> IDLE). Counter reads 0 in first RUN cycle.
//  - RUN: match = (cnt_value >= term_q) (>= guards against overshoot).
//    * stop: -> IDLE; cnt_enable=0, tick=0 this cycle.
//    * match: tick=1, cnt_enable=0, div<=0; per_q ? -> CLEAR : -> DONE.
//    * else: cnt_enable = (div==presc_q); div <= (div==presc_q) ? 0 : div+1.
//  - DONE: done=1, counter holds term_q. start&!stop -> relatch, CLEAR; stop -> IDLE.
//  - Latency: start sampled at edge k -> tick high in cycle k + 2 + term*(P+1).
//    Periodic period = term*(P+1) + 2 cycles (tick cycle + CLEAR included).
//  - term=0: tick in first RUN cycle, 2 cycles after start; no cnt_enable pulse.
//  - start in CLEAR/RUN: ignored, start_err=1 that cycle; term/prescale changes have no effect
//    until next accepted start. start with stop same cycle: stop wins, no start_err in IDLE.
//  - cnt_enable and cnt_reset never high in the same cycle (except during reset, enable=0).
//  - div width PRESCALE_W; P=2^PRESCALE_W-1 valid (div wraps to 0 on match only).
// TESTING (bench instantiates count_sequencer driving one 4-bit counter)
//  1 reset held 2 cycles mid-RUN -> IDLE, cnt_reset=1, busy=done=tick=cnt_enable=0, count=0.
//  2 one-shot term=3,P=0, start 1 cycle -> cnt_reset 1 cycle, cnt_enable 3 cycles, tick at k+5,
//    done=1 held, cnt_value stays 3.
//  3 periodic term=2,P=1 -> cnt_enable every 2nd RUN cycle, tick every 6 cycles for >=4 periods.
//  4 stop at cnt_value=1 -> IDLE next cycle, no tick; stop in the match cycle -> tick=0.
//  5 start while RUN with new term=9 -> start_err pulse, tick still at old term; term=0 -> tick k+2.
//  6 DONE then start term=15,P=15 -> tick at k+2+240, cnt_value=15, no wrap to 0.

Source files
------------

// File: rtl/count_sequencer.sv
// Control FSM for a 4-bit up-counter datapath: clears the counter, prescales its
// enable, compares the count against a latched terminal value and reports
// terminal events in one-shot or periodic mode.
module count_sequencer #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  periodic,
   input  logic [WIDTH-1:0]      term,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      cnt_value,
   output logic                  cnt_reset,
   output logic                  cnt_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  tick,
   output logic                  start_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state;
   logic [WIDTH-1:0]      term_q;
   logic [PRESCALE_W-1:0] presc_q;
   logic                  per_q;
   logic [PRESCALE_W-1:0] div;

   logic match;
   logic div_hit;

   // >= rather than == so an overshooting counter still terminates the run
   assign match   = (cnt_value >= term_q);
   assign div_hit = (div == presc_q);

   // State, latched run settings and prescale divider
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         term_q  <= '0;
         presc_q <= '0;
         per_q   <= 1'b0;
         div     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  term_q  <= term;
                  presc_q <= prescale;
                  per_q   <= periodic;
                  state   <= CLEAR;
               end
            end
            CLEAR: begin
               div   <= '0;
               state <= stop ? IDLE : RUN;
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (match) begin
                  div   <= '0;
                  state <= per_q ? CLEAR : DONE;
               end else if (div_hit) begin
                  div <= '0;
               end else begin
                  div <= div + PRESCALE_W'(1);
               end
            end
            DONE: begin
               if (stop) begin
                  state <= IDLE;
               end else if (start) begin
                  term_q  <= term;
                  presc_q <= prescale;
                  per_q   <= periodic;
                  state   <= CLEAR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded from state plus live stop/start; reset forces the counter clear
   always_comb begin
      cnt_reset  = 1'b0;
      cnt_enable = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      tick       = 1'b0;
      start_err  = 1'b0;
      if (reset) begin
         cnt_reset = 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               cnt_reset = 1'b1;
               busy      = 1'b1;
               start_err = start && !stop;
            end
            RUN: begin
               busy      = 1'b1;
               start_err = start && !stop;
               if (!stop) begin
                  if (match) begin
                     tick = 1'b1;
                  end else begin
                     cnt_enable = div_hit;
                  end
               end
            end
            DONE: begin
               done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench: count_sequencer driving one 4-bit counter, expected values hand-computed.
module tb_count_sequencer;

   logic       clock;
   logic       reset;
   logic       start;
   logic       stop;
   logic       periodic;
   logic [3:0] term;
   logic [3:0] prescale;
   logic [3:0] count;
   logic       cnt_reset;
   logic       cnt_enable;
   logic       busy;
   logic       done;
   logic       tick;
   logic       start_err;

   int n_tests = 0;
   int n_fail  = 0;

   count_sequencer #(.WIDTH(4), .PRESCALE_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .periodic   (periodic),
      .term       (term),
      .prescale   (prescale),
      .cnt_value  (count),
      .cnt_reset  (cnt_reset),
      .cnt_enable (cnt_enable),
      .busy       (busy),
      .done       (done),
      .tick       (tick),
      .start_err  (start_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The counter under control: sync reset, active-high enable
   always @(posedge clock) begin
      if (cnt_reset)       count <= 4'd0;
      else if (cnt_enable) count <= count + 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; land well after the edge
   task automatic next();
      @(posedge clock);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // From the current cycle, count cycles up to and including the next tick
   task automatic wait_tick(input int limit, output int n, output int en, output int rs);
      n  = 0;
      en = 0;
      rs = 0;
      for (int i = 1; i <= limit; i++) begin
         next();
         if (tick) begin
            n = i;
            break;
         end
         en += int'(cnt_enable);
         rs += int'(cnt_reset);
      end
      if (n == 0) check("tick_timeout", 32'd0, 32'd1);
   endtask

   // Present a start for one edge; returns in the CLEAR cycle
   task automatic do_start(input logic [3:0] t, input logic [3:0] p, input logic per);
      start    = 1'b1;
      term     = t;
      prescale = p;
      periodic = per;
      next();
      start = 1'b0;
      settle();
   endtask

   int n, en, rs;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      periodic = 1'b0;
      term     = 4'd0;
      prescale = 4'd0;
      next();
      next();
      check("rst_cnt_reset", 32'(cnt_reset), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_count",     32'(count),     32'd0);
      reset = 1'b0;
      next();
      check("idle_busy",     32'(busy),      32'd0);
      check("idle_cnt_rst",  32'(cnt_reset), 32'd0);

      // 1: reset held two cycles in the middle of a run
      do_start(4'd10, 4'd0, 1'b0);
      next(); next(); next();
      check("pre_rst_count", 32'(count), 32'd2);
      reset = 1'b1;
      settle();
      check("mid_rst_cnt_reset", 32'(cnt_reset),  32'd1);
      check("mid_rst_enable",    32'(cnt_enable), 32'd0);
      check("mid_rst_busy",      32'(busy),       32'd0);
      next(); next();
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_tick",  32'(tick),  32'd0);
      reset = 1'b0;
      settle();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_en",   32'(cnt_enable), 32'd0);

      // 2: one-shot term=3, P=0
      do_start(4'd3, 4'd0, 1'b0);
      check("os_clear_rst",  32'(cnt_reset),  32'd1);
      check("os_clear_en",   32'(cnt_enable), 32'd0);
      check("os_clear_busy", 32'(busy),       32'd1);
      wait_tick(50, n, en, rs);
      check("os_latency",    32'(n),     32'd4);
      check("os_enables",    32'(en),    32'd3);
      check("os_resets",     32'(rs),    32'd0);
      check("os_tick_count", 32'(count), 32'd3);
      next();
      check("os_done",  32'(done),  32'd1);
      check("os_busy",  32'(busy),  32'd0);
      check("os_tick1", 32'(tick),  32'd0);
      next(); next();
      check("os_done_hold",  32'(done),  32'd1);
      check("os_count_hold", 32'(count), 32'd3);

      // 3: periodic term=2, P=1, four periods
      stop = 1'b1; next(); stop = 1'b0;
      do_start(4'd2, 4'd1, 1'b1);
      wait_tick(50, n, en, rs);
      check("per_first", 32'(n),  32'd5);
      check("per_en0",   32'(en), 32'd2);
      for (int k = 0; k < 4; k++) begin
         wait_tick(50, n, en, rs);
         check("per_period", 32'(n),  32'd6);
         check("per_en",     32'(en), 32'd2);
         check("per_rst",    32'(rs), 32'd1);
      end
      stop = 1'b1; next(); stop = 1'b0; settle();
      check("per_stopped", 32'(busy), 32'd0);

      // start together with stop in IDLE: stop wins, no error
      start = 1'b1; stop = 1'b1; settle();
      check("idle_ss_err", 32'(start_err), 32'd0);
      next();
      start = 1'b0; stop = 1'b0; settle();
      check("idle_ss_busy", 32'(busy), 32'd0);

      // 4: stop at count 1, then stop in the match cycle
      do_start(4'd5, 4'd0, 1'b0);
      next(); next();
      check("stop_at1_count", 32'(count), 32'd1);
      stop = 1'b1; settle();
      check("stop_en",   32'(cnt_enable), 32'd0);
      check("stop_tick", 32'(tick),       32'd0);
      next();
      stop = 1'b0; settle();
      check("stop_idle", 32'(busy), 32'd0);
      check("stop_done", 32'(done), 32'd0);
      check("stop_cnt",  32'(count), 32'd1);
      do_start(4'd2, 4'd0, 1'b0);
      next(); next(); next();
      check("match_count", 32'(count), 32'd2);
      stop = 1'b1; settle();
      check("match_stop_tick", 32'(tick), 32'd0);
      next();
      stop = 1'b0; settle();
      check("match_stop_idle", 32'(busy), 32'd0);
      next();
      check("match_stop_late", 32'(tick), 32'd0);

      // 5: start during RUN with new term=9 is ignored
      do_start(4'd4, 4'd0, 1'b0);
      next(); next();
      start = 1'b1; term = 4'd9; settle();
      check("err_pulse", 32'(start_err), 32'd1);
      next();
      start = 1'b0; settle();
      check("err_clear", 32'(start_err), 32'd0);
      wait_tick(50, n, en, rs);
      check("err_old_term_lat", 32'(n),     32'd2);
      check("err_old_term_cnt", 32'(count), 32'd4);
      next();
      check("err_done", 32'(done), 32'd1);
      // term=0 from DONE: tick in the first RUN cycle, no enable
      start = 1'b1; term = 4'd0; prescale = 4'd0; settle();
      check("done_start_err", 32'(start_err), 32'd0);
      next();
      start = 1'b0; settle();
      wait_tick(50, n, en, rs);
      check("t0_latency", 32'(n),  32'd1);
      check("t0_enables", 32'(en), 32'd0);
      check("t0_count",   32'(count), 32'd0);
      next();
      check("t0_done", 32'(done), 32'd1);

      // 6: term=15, P=15 from DONE
      do_start(4'd15, 4'd15, 1'b0);
      wait_tick(400, n, en, rs);
      check("max_latency", 32'(n),     32'd241);
      check("max_enables", 32'(en),    32'd15);
      check("max_count",   32'(count), 32'd15);
      next(); next();
      check("max_done",    32'(done),  32'd1);
      check("max_no_wrap", 32'(count), 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
